// File: rtl/me_pe_col_sad.sv
// rtl/me_pe_col_sad.sv - motion-estimation PE column with shiftable SPR chain and pipelined column/half SAD
module me_pe_col_sad #(
    parameter int ROWS  = 16,
    parameter int PIX_W = 8,
    localparam int LVL    = $clog2(ROWS),
    localparam int SAD_W  = PIX_W + LVL,
    localparam int HSAD_W = PIX_W + LVL - 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_spr,
    input  logic                    en_cpr,
    input  logic [1:0]              sel,
    input  logic [PIX_W-1:0]        pixel_spr_in,
    input  logic [PIX_W-1:0]        pixel_cpr_in,
    input  logic [ROWS*PIX_W-1:0]   pixel_spr_right_in,
    input  logic                    sad_req,
    output logic [PIX_W-1:0]        pixel_spr_out,
    output logic [PIX_W-1:0]        pixel_cpr_out,
    output logic [ROWS*PIX_W-1:0]   pixel_spr_taps,
    output logic [ROWS*PIX_W-1:0]   ad,
    output logic                    sad_valid,
    output logic [SAD_W-1:0]        sad_total,
    output logic [HSAD_W-1:0]       sad_upper,
    output logic [HSAD_W-1:0]       sad_lower
);

    logic [PIX_W-1:0]       spr_q [ROWS];
    logic [PIX_W-1:0]       spr_d [ROWS];
    logic [PIX_W-1:0]       cpr_q [ROWS];
    logic [PIX_W-1:0]       cpr_d [ROWS];
    logic [ROWS*PIX_W-1:0]  ad_q;
    logic [LVL:0]           vld_q;
    logic [2*HSAD_W-1:0]    half_w;
    logic [HSAD_W-1:0]      upper_q;
    logic [HSAD_W-1:0]      lower_q;

    // SPR next state: down/up shift, right-neighbour load or clear; holds when disabled
    always_comb begin
        spr_d = spr_q;
        if (en_spr) begin
            case (sel)
                2'b00: begin
                    spr_d[0] = pixel_spr_in;
                    for (int i = 1; i < ROWS; i++) spr_d[i] = spr_q[i-1];
                end
                2'b01: begin
                    spr_d[ROWS-1] = pixel_spr_in;
                    for (int i = 0; i < ROWS-1; i++) spr_d[i] = spr_q[i+1];
                end
                2'b10: begin
                    for (int i = 0; i < ROWS; i++) spr_d[i] = pixel_spr_right_in[i*PIX_W +: PIX_W];
                end
                default: begin
                    for (int i = 0; i < ROWS; i++) spr_d[i] = '0;
                end
            endcase
        end
    end

    // CPR next state: single downward shift chain fed at row 0
    always_comb begin
        cpr_d = cpr_q;
        if (en_cpr) begin
            cpr_d[0] = pixel_cpr_in;
            for (int i = 1; i < ROWS; i++) cpr_d[i] = cpr_q[i-1];
        end
    end

    // Pixel registers for both chains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spr_q <= '{default: '0};
            cpr_q <= '{default: '0};
        end else begin
            spr_q <= spr_d;
            cpr_q <= cpr_d;
        end
    end

    genvar gi;
    for (gi = 0; gi < ROWS; gi++) begin : g_row
        assign pixel_spr_taps[gi*PIX_W +: PIX_W] = spr_q[gi];
        assign ad[gi*PIX_W +: PIX_W] = (spr_q[gi] >= cpr_q[gi]) ? (spr_q[gi] - cpr_q[gi])
                                                                : (cpr_q[gi] - spr_q[gi]);
    end

    assign pixel_spr_out = spr_q[ROWS-1];
    assign pixel_cpr_out = cpr_q[ROWS-1];

    // Stage 0 snapshot of the pre-edge ADs plus the valid shift register for every stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ad_q  <= '0;
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[LVL-1:0], sad_req};
            if (sad_req) ad_q <= ad;
        end
    end

    // Adder tree: level gl pairs neighbours of level gl-1, growing one bit per level
    genvar gl;
    for (gl = 1; gl <= LVL; gl++) begin : g_lvl
        localparam int N = ROWS >> gl;
        localparam int W = PIX_W + gl;
        logic [2*N*(W-1)-1:0] prev;
        logic [N*W-1:0]       sum_d;
        logic [N*W-1:0]       sum_q;

        if (gl == 1) begin : g_src_ad
            assign prev = ad_q;
        end else begin : g_src_lvl
            assign prev = g_lvl[gl-1].sum_q;
        end

        // Pairwise sums of the previous level
        always_comb begin
            sum_d = '0;
            for (int j = 0; j < N; j++) begin
                sum_d[j*W +: W] = {1'b0, prev[2*j*(W-1) +: W-1]} + {1'b0, prev[(2*j+1)*(W-1) +: W-1]};
            end
        end

        // Level register, loaded only when its input stage carries a request
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sum_q <= '0;
            else if (vld_q[gl-1]) sum_q <= sum_d;
        end
    end

    // The two half sums live one level below the root; low node is rows 0..ROWS/2-1
    if (LVL == 1) begin : g_half_ad
        assign half_w = ad_q;
    end else begin : g_half_lvl
        assign half_w = g_lvl[LVL-1].sum_q;
    end

    // Extra register on the halves so they line up with the root sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upper_q <= '0;
            lower_q <= '0;
        end else if (vld_q[LVL-1]) begin
            upper_q <= half_w[HSAD_W-1:0];
            lower_q <= half_w[2*HSAD_W-1:HSAD_W];
        end
    end

    assign sad_valid = vld_q[LVL];
    assign sad_total = g_lvl[LVL].sum_q;
    assign sad_upper = upper_q;
    assign sad_lower = lower_q;

endmodule

// File: tb/tb_me_pe_col_sad.sv
// tb/tb_me_pe_col_sad.sv - scoreboard bench for me_pe_col_sad (16x8 and 4x10 instances)
module tb_me_pe_col_sad;

    localparam int LAT  = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 16-row, 8-bit instance
    logic         en_spr = 0, en_cpr = 0, sad_req = 0;
    logic [1:0]   sel = 0;
    logic [7:0]   spr_in = 0, cpr_in = 0;
    logic [127:0] right_in = 0;
    logic [7:0]   spr_out, cpr_out;
    logic [127:0] taps, ad;
    logic         sad_valid;
    logic [11:0]  sad_total;
    logic [10:0]  sad_upper, sad_lower;

    me_pe_col_sad #(.ROWS(16), .PIX_W(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .en_spr(en_spr), .en_cpr(en_cpr), .sel(sel),
        .pixel_spr_in(spr_in), .pixel_cpr_in(cpr_in), .pixel_spr_right_in(right_in),
        .sad_req(sad_req), .pixel_spr_out(spr_out), .pixel_cpr_out(cpr_out),
        .pixel_spr_taps(taps), .ad(ad), .sad_valid(sad_valid),
        .sad_total(sad_total), .sad_upper(sad_upper), .sad_lower(sad_lower)
    );

    // 4-row, 10-bit instance
    logic         en_spr4 = 0, en_cpr4 = 0, sad_req4 = 0;
    logic [1:0]   sel4 = 0;
    logic [9:0]   spr_in4 = 0, cpr_in4 = 0;
    logic [39:0]  right_in4 = 0;
    logic [9:0]   spr_out4, cpr_out4;
    logic [39:0]  taps4, ad4;
    logic         sad_valid4;
    logic [11:0]  sad_total4;
    logic [10:0]  sad_upper4, sad_lower4;

    me_pe_col_sad #(.ROWS(4), .PIX_W(10)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en_spr(en_spr4), .en_cpr(en_cpr4), .sel(sel4),
        .pixel_spr_in(spr_in4), .pixel_cpr_in(cpr_in4), .pixel_spr_right_in(right_in4),
        .sad_req(sad_req4), .pixel_spr_out(spr_out4), .pixel_cpr_out(cpr_out4),
        .pixel_spr_taps(taps4), .ad(ad4), .sad_valid(sad_valid4),
        .sad_total(sad_total4), .sad_upper(sad_upper4), .sad_lower(sad_lower4)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct { int tot; int up; int lo; int due; } exp_t;
    exp_t exp_q[$];

    int m_spr[16];
    int m_cpr[16];

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack16(input int a[16]);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = a[i][7:0];
        return r;
    endfunction

    function automatic logic [127:0] model_ad();
        int d[16];
        for (int i = 0; i < 16; i++) d[i] = (m_spr[i] > m_cpr[i]) ? m_spr[i] - m_cpr[i] : m_cpr[i] - m_spr[i];
        return pack16(d);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output side of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (sad_valid) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_valid", 128'(sad_valid), 128'(0));
            end else begin
                e = exp_q.pop_front();
                check_val("valid_cycle", 128'(cyc), 128'(e.due));
                check_val("sad_total", 128'(sad_total), 128'(e.tot));
                check_val("sad_upper", 128'(sad_upper), 128'(e.up));
                check_val("sad_lower", 128'(sad_lower), 128'(e.lo));
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            check_val("missing_valid", 128'(sad_valid), 128'(1));
        end
    end

    // One clock: push expectation from pre-edge state, advance model, sample after edge
    task automatic step();
        int ns[16];
        int nc[16];
        exp_t e;
        if (sad_req && rst_n) begin
            e.tot = 0; e.up = 0; e.lo = 0;
            for (int i = 0; i < 16; i++) begin
                int d;
                d = (m_spr[i] > m_cpr[i]) ? m_spr[i] - m_cpr[i] : m_cpr[i] - m_spr[i];
                e.tot += d;
                if (i < 8) e.up += d; else e.lo += d;
            end
            e.due = cyc + LAT;
            exp_q.push_back(e);
        end
        ns = m_spr;
        nc = m_cpr;
        if (en_spr) begin
            case (sel)
                2'b00: begin ns[0] = int'(spr_in); for (int i = 1; i < 16; i++) ns[i] = m_spr[i-1]; end
                2'b01: begin ns[15] = int'(spr_in); for (int i = 0; i < 15; i++) ns[i] = m_spr[i+1]; end
                2'b10: for (int i = 0; i < 16; i++) ns[i] = int'(right_in[i*8 +: 8]);
                default: for (int i = 0; i < 16; i++) ns[i] = 0;
            endcase
        end
        if (en_cpr) begin
            nc[0] = int'(cpr_in);
            for (int i = 1; i < 16; i++) nc[i] = m_cpr[i-1];
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
            m_spr = ns;
            m_cpr = nc;
        end
    endtask

    task automatic idle();
        en_spr = 0; en_cpr = 0; sad_req = 0; sel = 0;
    endtask

    task automatic drain(input string tag);
        idle();
        repeat (LAT + 2) step();
        check_val(tag, 128'(exp_q.size()), 128'(0));
    endtask

    task automatic load_cpr_const(input logic [7:0] v);
        en_cpr = 1; cpr_in = v;
        repeat (16) step();
        en_cpr = 0;
    endtask

    initial begin
        logic [127:0] exp_taps;
        for (int i = 0; i < 16; i++) begin m_spr[i] = 0; m_cpr[i] = 0; end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Reset values
        check_val("rst_spr_out", 128'(spr_out), 128'(0));
        check_val("rst_cpr_out", 128'(cpr_out), 128'(0));
        check_val("rst_taps", taps, 128'(0));
        check_val("rst_ad", ad, 128'(0));
        check_val("rst_valid", 128'(sad_valid), 128'(0));
        check_val("rst_total", 128'(sad_total), 128'(0));
        check_val("rst_upper", 128'(sad_upper), 128'(0));
        check_val("rst_lower", 128'(sad_lower), 128'(0));

        // Zero SAD with latency check
        sad_req = 1; step(); sad_req = 0;
        drain("drain_zero");

        // Down-shift load spr[i]=i
        en_spr = 1; sel = 2'b00;
        for (int i = 0; i < 16; i++) begin spr_in = 8'(15 - i); step(); end
        check_val("down_load_taps", taps, pack16(m_spr));
        sel = 2'b01; spr_in = 8'hAA; step();
        exp_taps = '0;
        for (int i = 0; i < 15; i++) exp_taps[i*8 +: 8] = 8'(i + 1);
        exp_taps[127:120] = 8'hAA;
        check_val("up_taps", taps, exp_taps);
        check_val("up_spr_out", 128'(spr_out), 128'hAA);
        sel = 2'b00; spr_in = 8'h55; step();
        exp_taps = '0;
        exp_taps[7:0] = 8'h55;
        for (int i = 1; i < 16; i++) exp_taps[i*8 +: 8] = 8'(i);
        check_val("down_taps", taps, exp_taps);
        idle();

        // Varied cpr and an AD/SAD against the ramp
        en_cpr = 1;
        for (int i = 0; i < 16; i++) begin cpr_in = 8'($urandom_range(0, 255)); step(); end
        idle();
        check_val("cpr_out", 128'(cpr_out), 128'(m_cpr[15]));
        check_val("ad_ramp", ad, model_ad());
        sad_req = 1; step(); sad_req = 0;
        drain("drain_ramp");

        // Right load, disabled clear, enabled clear
        for (int i = 0; i < 16; i++) right_in[i*8 +: 8] = 8'(8'h10 + i);
        en_spr = 1; sel = 2'b10; step();
        check_val("right_taps", taps, right_in);
        en_spr = 0; sel = 2'b11; step();
        check_val("hold_taps", taps, right_in);
        en_spr = 1; sel = 2'b11; step();
        check_val("zero_taps", taps, 128'(0));
        idle();

        // Maximum SAD both polarities
        right_in = {128{1'b1}};
        en_spr = 1; sel = 2'b10; step(); idle();
        load_cpr_const(8'h00);
        sad_req = 1; step(); sad_req = 0;
        drain("drain_max1");
        en_spr = 1; sel = 2'b11; step(); idle();
        load_cpr_const(8'hFF);
        check_val("ad_max", ad, {128{1'b1}});
        sad_req = 1; step(); sad_req = 0;
        drain("drain_max2");

        // Back-to-back requests with same-edge shifts
        en_cpr = 1; en_spr = 1; sel = 2'b10; sad_req = 1;
        for (int k = 0; k < 3; k++) begin
            cpr_in = 8'($urandom_range(0, 255));
            for (int i = 0; i < 16; i++) right_in[i*8 +: 8] = 8'($urandom_range(0, 255));
            step();
        end
        drain("drain_b2b");

        // Random mixed traffic with request gaps
        for (int k = 0; k < 40; k++) begin
            en_spr = 1'($urandom_range(0, 1)); en_cpr = 1'($urandom_range(0, 1));
            sel = 2'($urandom_range(0, 3)); sad_req = 1'($urandom_range(0, 1));
            spr_in = 8'($urandom_range(0, 255)); cpr_in = 8'($urandom_range(0, 255));
            for (int i = 0; i < 16; i++) right_in[i*8 +: 8] = 8'($urandom_range(0, 255));
            step();
        end
        drain("drain_rand");
        check_val("rand_taps", taps, pack16(m_spr));

        // Reset with two requests in flight
        sad_req = 1; step(); step(); idle();
        rst_n = 0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin m_spr[i] = 0; m_cpr[i] = 0; end
        @(posedge clk); #1;
        rst_n = 1;
        check_val("midrst_taps", taps, 128'(0));
        drain("drain_midrst");

        // 4-row, 10-bit instance
        right_in4 = {10'd7, 10'd5, 10'd0, 10'd1023};
        en_spr4 = 1; sel4 = 2'b10; step(); en_spr4 = 0;
        en_cpr4 = 1;
        cpr_in4 = 10'd9;    step();
        cpr_in4 = 10'd2;    step();
        cpr_in4 = 10'd1023; step();
        cpr_in4 = 10'd0;    step();
        en_cpr4 = 0;
        sad_req4 = 1; step(); sad_req4 = 0;
        check_val("p4_early", 128'(sad_valid4), 128'(0));
        step(); step();
        check_val("p4_valid", 128'(sad_valid4), 128'(1));
        check_val("p4_upper", 128'(sad_upper4), 128'(2046));
        check_val("p4_lower", 128'(sad_lower4), 128'(5));
        check_val("p4_total", 128'(sad_total4), 128'(2051));
        step();
        check_val("p4_single", 128'(sad_valid4), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/me_pe_col_sad.md
# me_pe_col_sad

Parametrised column of motion-estimation processing elements for the H.264 inter-prediction systolic array. Each of `ROWS` PEs holds one search-window pixel (SPR) and one current-macroblock pixel (CPR). The SPR chain supports four shift modes. A registered adder tree turns the per-row absolute differences into a column SAD for the full column and for each half, with a valid pipeline. It extends the 16-row, 8-bit, unpipelined AD column with configurable depth and width, partition SADs and request/valid tracking.

## Interface
Parameters:
- `ROWS`, 16: number of PEs in the column; power of two, ≥2.
- `PIX_W`, 8: pixel width in bits.
- Derived: `LVL = $clog2(ROWS)`, `LAT = 1 + LVL`, `SAD_W = PIX_W + LVL`, `HSAD_W = PIX_W + LVL - 1`.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en_spr`  in  1  SPR chain update enable.
- `en_cpr`  in  1  CPR chain shift enable.
- `sel`  in  2  SPR source: 00 down, 01 up, 10 right, 11 zero.
- `pixel_spr_in`  in  PIX_W  SPR entry pixel; enters at row 0 when `sel`=00, at row ROWS-1 when `sel`=01.
- `pixel_cpr_in`  in  PIX_W  CPR entry pixel at row 0.
- `pixel_spr_right_in`  in  ROWS*PIX_W  right-neighbour SPR taps; row i at bits [PIX_W*(i+1)-1 : PIX_W*i].
- `sad_req`  in  1  capture ADs of the current register contents.
- `pixel_spr_out`  out  PIX_W  spr[ROWS-1].
- `pixel_cpr_out`  out  PIX_W  cpr[ROWS-1].
- `pixel_spr_taps`  out  ROWS*PIX_W  all spr registers, same packing as `pixel_spr_right_in`.
- `ad`  out  ROWS*PIX_W  combinational |spr[i]-cpr[i]|, same packing.
- `sad_valid`  out  1  SAD outputs valid this cycle.
- `sad_total`  out  SAD_W  sum over rows 0..ROWS-1.
- `sad_upper`  out  HSAD_W  sum over rows 0..ROWS/2-1.
- `sad_lower`  out  HSAD_W  sum over rows ROWS/2..ROWS-1.

## Operation
- SPR update (when `en_spr`=1), applied to row i:
  - `sel`=00: row 0 takes `pixel_spr_in`; row i>0 takes spr[i-1].
  - `sel`=01: row ROWS-1 takes `pixel_spr_in`; row i<ROWS-1 takes spr[i+1].
  - `sel`=10: row i takes right-in row i.
  - `sel`=11: row i takes 0.
- `en_spr`=0: SPR holds, regardless of `sel`.
- CPR shift (when `en_cpr`=1): cpr[0] takes `pixel_cpr_in`; cpr[i] takes cpr[i-1]. `en_cpr`=0: CPR holds. The SPR and CPR chains are independent; both may update in the same cycle.
- `ad` output: unsigned absolute difference of the current register values, exactly PIX_W bits wide, no saturation needed.
- SAD pipeline:
  - Stage 0: when `sad_req`=1, latch all ROWS ADs from the pre-edge register values. Registers that update on the same edge do not affect the captured ADs.
  - Stages 1..LVL: one registered binary adder level each. Each level widens by 1 bit, so no overflow is possible.
  - Halves: `sad_upper` and `sad_lower` are produced at level LVL-1 and registered once more, so they align with `sad_total`.
  - A valid bit travels with each stage; the pipeline accepts one request per cycle.
  - When `sad_req`=0, data stages may hold or toggle freely. Outputs are defined only while `sad_valid`=1.

## Timing
- Reset (`rst_n`=0, asynchronous): all spr, cpr, AD-stage, tree and valid registers are cleared. After reset, `pixel_spr_out`, `pixel_cpr_out`, `pixel_spr_taps`, `ad`, `sad_total`, `sad_upper` and `sad_lower` all read 0, and `sad_valid`=0.
- SPR and CPR updates are visible one cycle after the enabling edge.
- SAD latency: `sad_req` high in the cycle ending at edge t gives `sad_valid`=1 in the cycle following edge t+LAT-1. That is LAT cycles; ROWS=16 gives 5.
- Back-to-back requests produce back-to-back valids, in order. Gaps in requests produce identical gaps in valids.
- Reset asserted mid-pipeline: all in-flight results are dropped. No `sad_valid` appears until a new request is made after reset deasserts.
- `sel` and the enables are sampled every cycle. No multi-cycle hold is required.

## Test plan
- **Reset**: after reset with ROWS=16 and PIX_W=8, all outputs read 0. Assert `sad_req` at spr=cpr=0 -> exactly 5 cycles later `sad_valid`=1 with `sad_total`=0.
- **Down/up shift**: load spr[i]=i via 16 cycles of `sel`=00, then one `sel`=01 edge with `pixel_spr_in`=0xAA -> taps read 1..15,0xAA and `pixel_spr_out`=0xAA. Then one `sel`=00 edge with `pixel_spr_in`=0x55 -> taps read 0x55,1..15.
- **Right load / zero**: right-in row i = 0x10+i with `sel`=10 -> taps match right-in. Then `sel`=11 with `en_spr`=0 -> taps unchanged. Then `sel`=11 with `en_spr`=1 -> taps all 0.
- **Max SAD width**: all spr=0xFF, all cpr=0x00 -> `sad_total`=4080 (0xFF0), `sad_upper`=`sad_lower`=2040. Repeat with spr=0x00 and cpr=0xFF -> same values.
- **Pipelining and capture timing**: issue requests on 3 consecutive cycles while `en_cpr` shifts new values on the same edges. Each result must equal the SAD of the pre-edge contents, with valids on 3 consecutive cycles. Assert reset after the second request -> no valids appear afterwards.
- **Parametrisation**: ROWS=4, PIX_W=10, spr={1023,0,5,7}, cpr={0,1023,2,9} -> after LAT=3 cycles, `sad_upper`=2046, `sad_lower`=5, `sad_total`=2051.
